// File: rtl/ps2_host_tx_if.sv
// Command handshake between the game-control logic and the PS/2 host transmitter.
// The master issues bytes, the slave (transmitter) reports ready/busy and completion.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the device,
// ACK check and line-idle wait, with open-drain pull-low enables on both pins.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned SETUP_CYCLES   = 100,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CNT_W          = 21
) (
  input  logic         clk,
  input  logic         clrn,
  ps2_host_tx_if.slave host,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StSend,
    StAck,
    StWaitIdle,
    StDone,
    StError
  } state_e;

  localparam logic [CNT_W-1:0] InhibitLast = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SetupLast   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       clk_sync_q, data_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [10:0]      frame_q, frame_d;

  logic fall;
  logic timeout;
  logic tx_ready_c, busy_c, done_c, err_c;
  logic clk_oe_c, data_oe_c;

  // sync[0] is the newest sample; sync[2] the oldest.
  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign timeout = (cnt_q == TimeoutLast);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[1:0], ps2_data_in};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    unique case (state_q)
      StIdle: begin
        if (host.tx_valid) begin
          // Frame LSB first: start 0, data, odd parity, stop 1.
          frame_d = {1'b1, ~^host.tx_data, host.tx_data, 1'b0};
          cnt_d   = '0;
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d   = '0;
          state_d = StStart;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StSend;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSend: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          state_d = StError;
        end else if (fall) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          state_d = StError;
        end else if (fall) begin
          state_d = data_sync_q[1] ? StError : StWaitIdle;
        end
      end
      StWaitIdle: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          state_d = StError;
        end else if (clk_sync_q[1] && data_sync_q[1]) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode the registered state only, so reset releases the lines immediately.
  always_comb begin
    tx_ready_c = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    err_c      = 1'b0;
    clk_oe_c   = 1'b0;
    data_oe_c  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_ready_c = 1'b1;
        busy_c     = 1'b0;
      end
      StInhibit: clk_oe_c = 1'b1;
      StStart: begin
        clk_oe_c  = 1'b1;
        data_oe_c = 1'b1;
      end
      StSend:     data_oe_c = ~frame_q[idx_q];
      StAck:      data_oe_c = 1'b0;
      StWaitIdle: data_oe_c = 1'b0;
      StDone:     done_c    = 1'b1;
      StError:    err_c     = 1'b1;
      default: begin
        tx_ready_c = 1'b0;
      end
    endcase
  end

  assign host.tx_ready = tx_ready_c;
  assign host.busy     = busy_c;
  assign host.done     = done_c;
  assign host.err      = err_c;
  assign ps2_clk_oe    = clk_oe_c;
  assign ps2_data_oe   = data_oe_c;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
  localparam int unsigned INH = 40;
  localparam int unsigned SET = 10;
  localparam int unsigned TMO = 500;
  localparam int HALF = 10;
  localparam int MODE_ACK = 0;
  localparam int MODE_NACK = 1;
  localparam int MODE_SILENT = 2;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if host();
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_line, ps2_data_line;
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (21)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .host       (host),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int n_checks = 0;
  int n_pass = 0;
  int pulses = 0;
  int dev_mode = MODE_ACK;
  bit dev_active = 1'b0;
  bit dev_discard = 1'b0;

  logic        exp_done_q[$];
  logic [10:0] exp_frame_q[$];
  logic [10:0] obs_frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference frame from the protocol rules: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Monitor: outcome pulses and device-observed frames against the scoreboard queues.
  always @(negedge clk) begin : monitor
    logic e;
    if (clrn && (host.done === 1'b1 || host.err === 1'b1)) begin
      pulses++;
      check("done_err_exclusive", 32'(host.done & host.err), 32'd0);
      check("outcome_expected", 32'(exp_done_q.size() != 0), 32'd1);
      if (exp_done_q.size() != 0) begin
        e = exp_done_q.pop_front();
        check("outcome_done", 32'(host.done), 32'(e));
      end
    end
    if (obs_frame_q.size() != 0) begin
      check("frame_expected", 32'(exp_frame_q.size() != 0), 32'd1);
      if (exp_frame_q.size() != 0)
        check("frame_bits", 32'(obs_frame_q.pop_front()), 32'(exp_frame_q.pop_front()));
      else
        void'(obs_frame_q.pop_front());
    end
  end

  // Device: answers a request-to-send by clocking 11 bits and then ACKing (or not).
  initial begin : device
    logic [10:0] bits;
    forever begin
      @(negedge ps2_clk_oe);
      if (ps2_data_oe !== 1'b1 || dev_mode == MODE_SILENT) continue;
      dev_active = 1'b1;
      repeat (HALF) @(negedge clk);
      bits[0] = ps2_data_line;
      for (int i = 1; i <= 10; i++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        bits[i] = ps2_data_line;
        repeat (HALF) @(negedge clk);
      end
      if (dev_mode == MODE_ACK) dev_data_low = 1'b1;
      repeat (3) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
      if (!dev_discard) obs_frame_q.push_back(bits);
      dev_active = 1'b0;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic [7:0] b, input int mode, input bit track);
    int n_clk, n_data, guard;
    dev_mode = mode;
    guard = 0;
    while (host.tx_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 32'(host.tx_ready), 32'd1);
    if (track) begin
      exp_done_q.push_back(mode == MODE_ACK);
      if (mode != MODE_SILENT) exp_frame_q.push_back(ref_frame(b));
    end
    host.tx_data  = b;
    host.tx_valid = 1'b1;
    @(negedge clk);
    host.tx_valid = 1'b0;
    host.tx_data  = 8'($urandom);
    n_clk  = 0;
    n_data = 0;
    guard  = 0;
    while (ps2_clk_oe === 1'b1 && guard < int'(INH + SET) + 100) begin
      if (ps2_data_oe === 1'b1) n_data++;
      n_clk++;
      @(negedge clk);
      guard++;
    end
    check("clk_low_cycles", n_clk, INH + SET);
    check("data_lead_cycles", n_data, SET);
    check("start_held_at_release", 32'(ps2_data_oe), 32'd1);
  endtask

  task automatic wait_outcome(output int cyc, output logic was_done);
    cyc = 0;
    while (host.done !== 1'b1 && host.err !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("outcome_seen", 32'(host.done === 1'b1 || host.err === 1'b1), 32'd1);
    was_done = host.done;
  endtask

  task automatic wait_device_idle();
    int guard;
    guard = 0;
    while (dev_active && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("device_idle", 32'(dev_active), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic after_outcome();
    @(negedge clk);
    check("busy_after", 32'(host.busy), 32'd0);
    check("ready_after", 32'(host.tx_ready), 32'd1);
    check("oe_after", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
  endtask

  task automatic stray_falls(input int n);
    for (int i = 0; i < n; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  initial begin : stimulus
    int cyc;
    int p0;
    int mode;
    logic was_done;
    logic [7:0] b;
    host.tx_data  = 8'h00;
    host.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(host.tx_ready), 32'd1);
    check("rst_busy", 32'(host.busy), 32'd0);
    check("rst_done_err", 32'({host.done, host.err}), 32'd0);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    stray_falls(3);
    repeat (10) @(negedge clk);
    check("stray_idle_no_pulse", pulses, 0);
    check("stray_idle_ready", 32'(host.tx_ready), 32'd1);

    send_req(8'hED, MODE_ACK, 1'b1);
    wait_outcome(cyc, was_done);
    check("ed_done", 32'(was_done), 32'd1);
    check("ed_busy_with_done", 32'(host.busy), 32'd1);
    after_outcome();
    wait_device_idle();

    send_req(8'h07, MODE_ACK, 1'b1);
    wait_outcome(cyc, was_done);
    check("07_done", 32'(was_done), 32'd1);
    after_outcome();
    wait_device_idle();

    send_req(8'hFF, MODE_NACK, 1'b1);
    wait_outcome(cyc, was_done);
    check("nack_err", 32'(host.err), 32'd1);
    check("nack_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    after_outcome();
    wait_device_idle();

    send_req(8'hAA, MODE_SILENT, 1'b1);
    wait_outcome(cyc, was_done);
    check("timeout_err", 32'(host.err), 32'd1);
    check("timeout_latency", cyc, TMO);
    after_outcome();

    send_req(8'hF4, MODE_ACK, 1'b1);
    repeat (50) @(negedge clk);
    host.tx_data  = 8'h55;
    host.tx_valid = 1'b1;
    @(negedge clk);
    host.tx_valid = 1'b0;
    wait_outcome(cyc, was_done);
    check("f4_done", 32'(was_done), 32'd1);
    after_outcome();
    wait_device_idle();
    repeat (INH + SET) @(negedge clk);
    check("ignored_0x55_no_restart", 32'(host.tx_ready), 32'd1);

    dev_discard = 1'b1;
    send_req(8'hF4, MODE_ACK, 1'b0);
    repeat (60) @(negedge clk);
    p0 = pulses;
    #2;
    clrn = 1'b0;
    #1;
    check("abort_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("abort_ready", 32'(host.tx_ready), 32'd1);
    check("abort_busy", 32'(host.busy), 32'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    wait_device_idle();
    check("abort_no_pulse", pulses, p0);
    dev_discard = 1'b0;

    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      mode = ($urandom_range(0, 3) == 0) ? MODE_NACK : MODE_ACK;
      if ($urandom_range(0, 3) == 0) stray_falls(2);
      send_req(b, mode, 1'b1);
      wait_outcome(cyc, was_done);
      check("rand_outcome", 32'(was_done), 32'(mode == MODE_ACK));
      after_outcome();
      wait_device_idle();
    end

    repeat (20) @(negedge clk);
    check("scoreboard_outcomes_drained", exp_done_q.size(), 0);
    check("scoreboard_frames_drained", exp_frame_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
